udma_spim_cmd_arbiter: RTL

//  Shares the single SPI-master command channel (udma_spim_ctrl command input) between N_REQ

---
 rtl/udma_spim_arb_pkg.sv | 17 +
 rtl/udma_spim_rr_pick.sv | 33 +++
 rtl/udma_spim_cmd_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/udma_spim_arb_pkg.sv
// Shared types and width helpers for the SPI-master command arbiter.
package udma_spim_arb_pkg;

    localparam int unsigned CmdW   = 32;
    localparam int unsigned MaxReq = 8;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StWaitEot
    } arb_state_e;

    function automatic int unsigned id_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udma_spim_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after ptr_i, wrapping.
module udma_spim_rr_pick
    import udma_spim_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IdW  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IdW-1:0]   ptr_i,
    output logic [IdW-1:0]   grant_o,
    output logic             any_valid_o
);

    logic           found;
    logic [IdW-1:0] idx;

    always_comb begin
        grant_o = ptr_i;
        found   = 1'b0;
        idx     = '0;
        // Offsets 1..N_REQ so the previous winner is considered last.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = IdW'((32'(ptr_i) + i) % N_REQ);
            if (!found && valid_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
    end

    assign any_valid_o = |valid_i;

endmodule

// File: rtl/udma_spim_cmd_arbiter.sv
// Packet-granular round-robin arbiter sharing the SPI-master command channel,
// with optional grant hold until the controller's end-of-transfer.
module udma_spim_cmd_arbiter
    import udma_spim_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned TIMEOUT_W = 16,
    localparam int unsigned IdW      = id_width(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_wait_eot_i,
    input  logic [N_REQ*CmdW-1:0]   req_data_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [CmdW-1:0]         cmd_data_o,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    input  logic                    eot_i,
    output logic [IdW-1:0]          grant_id_o,
    output logic                    busy_o,
    output logic                    timeout_o
);

    // Reaching this value means the next increment would hit all-ones: the wait expires.
    localparam logic [TIMEOUT_W-1:0] CntLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    arb_state_e           state_q;
    logic [IdW-1:0]       ptr_q;
    logic [IdW-1:0]       grant_q;
    logic [IdW-1:0]       pick;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 timeout_q;
    logic                 any_valid;
    logic                 in_xfer;
    logic                 hs_last;

    udma_spim_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .valid_i     (req_valid_i),
        .ptr_i       (ptr_q),
        .grant_o     (pick),
        .any_valid_o (any_valid)
    );

    assign in_xfer     = (state_q == StXfer);
    assign cmd_valid_o = in_xfer & req_valid_i[grant_q];
    assign cmd_data_o  = in_xfer ? req_data_i[32'(grant_q)*CmdW +: CmdW] : '0;
    assign hs_last     = cmd_valid_o & cmd_ready_i & req_last_i[grant_q];

    always_comb begin
        req_ready_o = '0;
        if (in_xfer) begin
            req_ready_o[grant_q] = cmd_ready_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ptr_q     <= IdW'(N_REQ - 1);
            grant_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        grant_q <= pick;
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    // eot_i here belongs to an earlier transfer and is ignored.
                    if (hs_last) begin
                        ptr_q   <= grant_q;
                        cnt_q   <= '0;
                        state_q <= cfg_wait_eot_i ? StWaitEot : StIdle;
                    end
                end
                StWaitEot: begin
                    if (eot_i) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_id_o = grant_q;
    assign busy_o     = (state_q != StIdle);
    assign timeout_o  = timeout_q;

endmodule
